// File: rtl/r2r_pkg.sv
// Shared R2R ladder definitions: playback FSM states and midscale code helper.
package r2r_pkg;

  typedef enum logic [1:0] {
    DAC_IDLE,
    DAC_PRIME,
    DAC_RUN
  } dac_state_t;

  // Ladder code for the centre of the output range (unsigned binary convention).
  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/r2r_sample_fifo.sv
// Synchronous sample FIFO with wrapping pointers.
// Ports: clk, reset (async, active-low), push/push_data, pop, head (oldest
// entry), full, empty, level (occupancy 0..DEPTH).
module r2r_sample_fifo
  import r2r_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/r2r_dac_streamer.sv
// Buffers producer samples and plays them onto the R2R ladder every
// rate_div+1 cycles, priming the FIFO to half full before starting.
// Ports: clk, reset (async, active-low), enable, rate_div, s_data/s_valid/
// s_ready (producer handshake), r2r_out, sample_strobe, underrun, level.
module r2r_dac_streamer
  import r2r_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DIV_WIDTH-1:0]    rate_div,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WIDTH-1:0]        r2r_out,
  output logic                    sample_strobe,
  output logic                    underrun,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]    PRIME_LVL = LW'(DEPTH / 2);
  localparam logic [WIDTH-1:0] MID_CODE  = WIDTH'(midscale(WIDTH));

  dac_state_t           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     r2r_q, r2r_d;
  logic                 strobe_q, strobe_d;
  logic                 underrun_q, underrun_d;

  logic                 fifo_full, fifo_empty;
  logic [WIDTH-1:0]     fifo_head;
  logic [LW-1:0]        fifo_level;
  logic                 push, pop, tick;

  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;

  r2r_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // >= rather than == so a live decrease of rate_div below the count
  // still ticks instead of waiting for the counter to wrap.
  assign tick = (state_q == DAC_RUN) && enable && (cnt_q >= rate_div);
  // Emptiness is sampled before this cycle's push: no fall-through.
  assign pop  = tick && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r2r_d      = pop ? fifo_head : r2r_q;
    strobe_d   = pop;
    underrun_d = tick && fifo_empty;
    case (state_q)
      DAC_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = DAC_PRIME;
      end
      DAC_PRIME: begin
        cnt_d = '0;
        if (!enable)                       state_d = DAC_IDLE;
        else if (fifo_level >= PRIME_LVL)  state_d = DAC_RUN;
      end
      DAC_RUN: begin
        if (!enable) begin
          state_d = DAC_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DAC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DAC_IDLE;
      cnt_q      <= '0;
      r2r_q      <= MID_CODE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r2r_q      <= r2r_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign r2r_out       = r2r_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;
  assign level         = fifo_level;

endmodule

// File: tb/tb_r2r_dac_streamer.sv
module tb_r2r_dac_streamer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] rate_div;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  r2r_out;
  logic        sample_strobe;
  logic        underrun;
  logic [2:0]  level;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  r2r_dac_streamer #(
    .WIDTH     (8),
    .DEPTH     (4),
    .DIV_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .rate_div      (rate_div),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .r2r_out       (r2r_out),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic [15:0] rd;
    logic        v;
    logic [7:0]  d;
    logic [7:0]  r2r;
    logic        stb;
    logic        und;
    logic [2:0]  lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic [15:0] rd, input logic v,
                              input logic [7:0] d, input logic [7:0] r2r,
                              input logic stb, input logic und, input logic [2:0] lvl);
    vec_t e;
    e.en = en; e.rd = rd; e.v = v; e.d = d;
    e.r2r = r2r; e.stb = stb; e.und = und; e.lvl = lvl;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Prime to half full, then play 0x10/0x20/0x30 at rate_div=3, then underrun.
    add(1, 3, 1, 8'h10, 8'h80, 0, 0, 1);
    add(1, 3, 1, 8'h20, 8'h80, 0, 0, 2);
    add(1, 3, 1, 8'h30, 8'h80, 0, 0, 3);
    for (int k = 0; k < 3; k++) add(1, 3, 0, 0, 8'h80, 0, 0, 3);
    add(1, 3, 0, 0, 8'h10, 1, 0, 2);
    for (int k = 0; k < 3; k++) add(1, 3, 0, 0, 8'h10, 0, 0, 2);
    add(1, 3, 0, 0, 8'h20, 1, 0, 1);
    for (int k = 0; k < 3; k++) add(1, 3, 0, 0, 8'h20, 0, 0, 1);
    add(1, 3, 0, 0, 8'h30, 1, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) add(1, 3, 0, 0, 8'h30, 0, 0, 0);
      add(1, 3, 0, 0, 8'h30, 0, 1, 0);
    end
    // Disabled prefill to full with backpressure; fifth sample waits for a pop.
    add(0, 1, 1, 8'hA1, 8'h30, 0, 0, 1);
    add(0, 1, 1, 8'hA2, 8'h30, 0, 0, 2);
    add(0, 1, 1, 8'hA3, 8'h30, 0, 0, 3);
    add(0, 1, 1, 8'hA4, 8'h30, 0, 0, 4);
    add(0, 1, 1, 8'hA5, 8'h30, 0, 0, 4);
    add(0, 1, 1, 8'hA5, 8'h30, 0, 0, 4);
    add(1, 1, 1, 8'hA5, 8'h30, 0, 0, 4);
    add(1, 1, 1, 8'hA5, 8'h30, 0, 0, 4);
    add(1, 1, 1, 8'hA5, 8'h30, 0, 0, 4);
    add(1, 1, 1, 8'hA5, 8'hA1, 1, 0, 3);
    add(1, 1, 1, 8'hA5, 8'hA1, 0, 0, 4);
    add(1, 1, 0, 0,     8'hA2, 1, 0, 3);
    add(1, 1, 0, 0,     8'hA2, 0, 0, 3);
    add(1, 1, 0, 0,     8'hA3, 1, 0, 2);
    add(1, 1, 0, 0,     8'hA3, 0, 0, 2);
    add(1, 1, 0, 0,     8'hA4, 1, 0, 1);
    add(1, 1, 0, 0,     8'hA4, 0, 0, 1);
    add(1, 1, 0, 0,     8'hA5, 1, 0, 0);
    add(1, 1, 0, 0,     8'hA5, 0, 0, 0);
    // rate_div=0, continuous producer; first push lands in an empty FIFO on a tick.
    add(1, 0, 1, 8'hB0, 8'hA5, 0, 1, 1);
    add(1, 0, 1, 8'hB1, 8'hB0, 1, 0, 1);
    add(1, 0, 1, 8'hB2, 8'hB1, 1, 0, 1);
    add(1, 0, 1, 8'hB3, 8'hB2, 1, 0, 1);
    add(1, 0, 0, 0,     8'hB3, 1, 0, 0);
    add(1, 0, 0, 0,     8'hB3, 0, 1, 0);
    // Disable mid-stream, re-enable, lower rate_div 10 -> 2 at counter 7.
    add(1, 10, 1, 8'hC0, 8'hB3, 0, 0, 1);
    add(1, 10, 1, 8'hC1, 8'hB3, 0, 0, 2);
    add(1, 10, 1, 8'hC2, 8'hB3, 0, 0, 3);
    for (int k = 0; k < 13; k++) add(0, 10, 0, 0, 8'hB3, 0, 0, 3);
    for (int k = 0; k < 9; k++)  add(1, 10, 0, 0, 8'hB3, 0, 0, 3);
    add(1, 2, 0, 0, 8'hC0, 1, 0, 2);
    for (int k = 0; k < 2; k++) add(1, 2, 0, 0, 8'hC0, 0, 0, 2);
    add(1, 2, 0, 0, 8'hC1, 1, 0, 1);
    for (int k = 0; k < 2; k++) add(1, 2, 0, 0, 8'hC1, 0, 0, 1);
    add(1, 2, 0, 0, 8'hC2, 1, 0, 0);
    for (int k = 0; k < 2; k++) add(1, 2, 0, 0, 8'hC2, 0, 0, 0);
    add(1, 2, 0, 0, 8'hC2, 0, 1, 0);

    reset    = 1'b0;
    enable   = 1'b0;
    rate_div = '0;
    s_data   = '0;
    s_valid  = 1'b0;
    step();
    step();
    chk("reset_r2r",      r2r_out,       8'h80);
    chk("reset_strobe",   sample_strobe, 0);
    chk("reset_underrun", underrun,      0);
    chk("reset_level",    level,         0);
    chk("reset_s_ready",  s_ready,       1);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      enable   = tbl[i].en;
      rate_div = tbl[i].rd;
      s_valid  = tbl[i].v;
      s_data   = tbl[i].d;
      step();
      chk($sformatf("row%0d_r2r", i),      r2r_out,       tbl[i].r2r);
      chk($sformatf("row%0d_strobe", i),   sample_strobe, tbl[i].stb);
      chk($sformatf("row%0d_underrun", i), underrun,      tbl[i].und);
      chk($sformatf("row%0d_level", i),    level,         tbl[i].lvl);
      chk($sformatf("row%0d_s_ready", i),  s_ready,       (tbl[i].lvl != 3'd4) ? 1 : 0);
    end

    // Asynchronous reset mid-RUN with three samples buffered.
    rate_div = 16'd100;
    s_valid  = 1'b1;
    s_data   = 8'hD0; step();
    s_data   = 8'hD1; step();
    s_data   = 8'hD2; step();
    s_valid  = 1'b0;
    chk("prereset_level", level,   3);
    chk("prereset_r2r",   r2r_out, 8'hC2);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_r2r",    r2r_out,       8'h80);
    chk("async_reset_level",  level,         0);
    chk("async_reset_strobe", sample_strobe, 0);
    chk("async_reset_sready", s_ready,       1);
    step();
    step();
    reset    = 1'b1;
    enable   = 1'b1;
    rate_div = 16'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("post_reset%0d_strobe", k),   sample_strobe, 0);
      chk($sformatf("post_reset%0d_underrun", k), underrun,      0);
      chk($sformatf("post_reset%0d_r2r", k),      r2r_out,       8'h80);
      chk($sformatf("post_reset%0d_level", k),    level,         0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/r2r_dac_streamer.md
# r2r_dac_streamer

Playback-side counterpart to the R2R SAR capture path: buffers digital samples from an upstream producer and drives them onto the R2R resistor ladder at a programmable sample rate. A small FIFO absorbs producer jitter, and a prime/run state machine avoids start-up underrun. It sits between any sample source (waveform ROM, captured-value replay, host register) and the board R2R output pins, sharing the ladder's WIDTH and code convention (unsigned binary, 0 = ladder minimum).

## Interface
- WIDTH, 8, R2R ladder code width
- DEPTH, 4, FIFO depth; power of 2, ≥2
- DIV_WIDTH, 16, width of the sample-rate divider
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable  in  1  playback enable; level-sensitive
- rate_div  in  DIV_WIDTH  output period minus one, in clk cycles
- s_data  in  WIDTH  sample from producer
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; transfer when s_valid && s_ready
- r2r_out  out  WIDTH  registered code to ladder
- sample_strobe  out  1  one-cycle pulse, concurrent with each r2r_out update
- underrun  out  1  one-cycle pulse on a tick with an empty FIFO
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- States: IDLE, PRIME, RUN.
- IDLE: divider counter held at 0. No pops. Goes to PRIME when enable=1.
- PRIME: goes to RUN when level ≥ DEPTH/2. Goes to IDLE when enable=0.
- RUN: counter increments each cycle. Tick when counter ≥ rate_div; the counter returns to 0 on a tick. The ≥ compare covers a live rate_div decrease. rate_div=0 gives a tick every cycle. Goes to IDLE when enable=0; the counter clears and no tick occurs that cycle.
- Tick with level>0: pop the head into r2r_out and pulse sample_strobe.
- Tick with level=0: r2r_out holds its value, underrun pulses, and the state stays RUN. There is no re-prime.
- s_ready = (level != DEPTH). It is independent of enable, so the FIFO can be prefilled in IDLE.
- Push and pop in the same cycle: level unchanged; data order preserved.
- Push into an empty FIFO in the same cycle as a tick: no fall-through. This is an underrun; the pushed sample is retained.
- enable falling: FIFO contents and r2r_out are retained. No flush.
- Reset:
  - r2r_out = midscale (1 << (WIDTH-1)).
  - sample_strobe = 0, underrun = 0, level = 0.
  - FIFO empty, counter = 0, state = IDLE.
  - Asserting reset mid-operation discards all buffered samples immediately.

## Timing
- Push: a sample accepted at edge N is counted in level after edge N; it is poppable by a tick from cycle N+1.
- PRIME→RUN: the transition occurs on the edge after the cycle in which level ≥ DEPTH/2.
- First pop: in the rate_div-th RUN cycle, counting the first RUN cycle as cycle 0. r2r_out changes on that cycle's closing edge.
- Output period: exactly rate_div+1 cycles while rate_div is constant.
- sample_strobe and underrun are registered. Each is high for the single cycle following its tick edge, aligned with the new r2r_out.
- s_ready is combinational from level only, with no path from s_valid. When full, s_ready is low, so a same-cycle pop does not enable a push in that cycle.

## Structure
- Package r2r_pkg holds:
  - typedef enum logic [1:0] dac_state_t {DAC_IDLE, DAC_PRIME, DAC_RUN};
  - a midscale(width) constant function, shared with the SAR controller.
- Sub-module r2r_sample_fifo (WIDTH, DEPTH):
  - synchronous FIFO with wrapping read/write pointers and a level output;
  - push/pop inputs, head data output, full/empty outputs.
- Top level holds the FSM, divider counter and output registers.

## Test plan
- Reset: assert reset=0 mid-RUN with 3 samples buffered. Required: r2r_out=0x80 and level=0 immediately (asynchronous); no strobe after release.
- Prime and rate: enable=1, rate_div=3, push 0x10, 0x20, 0x30. Required:
  - RUN entered the edge after level=2;
  - r2r_out steps 0x10, 0x20, 0x30 at 4-cycle spacing;
  - one sample_strobe per step.
- Underrun: continue the previous case with no further pushes. Required: underrun pulses every 4 cycles; r2r_out holds 0x30; state remains RUN.
- Full/backpressure: enable=0, push 5 samples with s_valid held high. Required:
  - s_ready low after the 4th accept, with level=4;
  - 5th sample accepted only after enable=1 and the first pop;
  - order preserved.
- rate_div=0 with a continuous producer: r2r_out updates every cycle and sample_strobe stays high; level stable under simultaneous push/pop.
- Disable mid-stream, then rate_div lowered from 10 to 2 at counter 7: after enable=0, no pops and r2r_out/FIFO retained; after re-enable, tick at counter ≥2 with no lockup.
